lsu_initiator: RTL
==================

# lsu_initiator

Load/store initiator between the single-cycle MIPS datapath and a word-wide data memory with a valid/ready handshake. It accepts CPU load/store requests of byte, halfword or word size and issues word-aligned memory transactions. Sub-word stores use read-modify-write. Load data is lane-extracted and sign- or zero-extended, and the CPU is stalled until the access completes.

## Interface
Parameters:
- BASE, 32'h0000_2000, byte address of data memory word 0
- WORDS, 512, number of 32-bit words in the data region

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  1  CPU access request, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word; 11 treated as error
- unsigned_ld  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- addr  in  32  CPU byte address
- wdata  in  32  store data, right-justified for sub-word sizes
- stall  out  1  holds CPU PC/pipeline while access in flight
- rdata  out  32  extended load result, valid while done=1
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; misaligned, out-of-range or size=11
- m_valid  out  1  memory request valid
- m_we  out  1  memory write enable, qualified by m_valid
- m_addr  out  32  word-aligned byte address (addr[1:0]=00), absolute
- m_wdata  out  32  full-word write data
- m_ready  in  1  memory accepts request; for reads, m_rdata valid this cycle
- m_rdata  in  32  memory read word

## Operation
- Little-endian lanes: byte k (addr[1:0]=k) is word bits [8k+7:8k]; halfword at addr[1]=h is bits [16h+15:16h].
- Request is captured into internal registers (addr, wdata, size, is_store, unsigned_ld) on the IDLE edge with req=1.
- Error check at capture: half with addr[0]=1, word with addr[1:0]!=0, size=11, addr<BASE, or addr>=BASE+4*WORDS. On error there is no memory transaction; go to RESP with err=1 and rdata=0.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: req & error -> RESP. req & (load | sub-word store) -> READ. req & word store -> WRITE.
  - READ: m_valid=1, m_we=0. On m_ready, capture m_rdata. Load -> RESP. Sub-word store -> WRITE, with merged word = captured word with target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - WRITE: m_valid=1, m_we=1, m_wdata = merged word (or wdata for word store). On m_ready -> RESP.
  - RESP: done=1 for exactly one cycle, rdata/err valid; -> IDLE.
- Load result: selected lane, extended to 32 bits per unsigned_ld; word loads pass through unchanged. Stores return rdata=0.
- m_valid, m_we, m_addr and m_wdata are held stable while m_valid=1 and m_ready=0.
- stall = (state==READ) | (state==WRITE) | (state==IDLE & req). stall is 0 in RESP, so the CPU advances on the done cycle.
- req while not in IDLE is ignored. The CPU is stalled, so the same request cannot re-fire.

## Timing
- All outputs except stall are registered. stall is combinational from state and req.
- Reset values: state IDLE; m_valid 0, m_we 0, m_addr 0, m_wdata 0, rdata 0, done 0, err 0. stall = req.
- Zero-wait latency (m_ready=1 constantly), counting from request edge E0:
  - load: READ in cycle 1, done in cycle 2
  - word store: WRITE in cycle 1, done in cycle 2
  - sub-word store: READ in cycle 1, WRITE in cycle 2, done in cycle 3
  - error: done and err in cycle 1
- Each wait cycle (m_ready=0) extends READ or WRITE by one cycle.
- rst during READ or WRITE: state is IDLE and m_valid is 0 after the next edge. No done pulse for the aborted access. A pending write may or may not have completed at memory, depending on m_ready in that same cycle.
- rst and req in the same cycle: reset wins and the request is not captured.
- In RESP, a new req is not accepted until back in IDLE, the cycle after done.

## Test plan
- Load word, zero-wait: mem word at 0x2004 = 0x8899AABB; lw addr=0x2004 -> m_addr=0x2004, done 2 cycles after req, rdata=0x8899AABB, err=0.
- Byte and half loads: same word, lb at 0x2007 -> 0xFFFFFF88; lbu at 0x2007 -> 0x00000088; lh at 0x2004 -> 0xFFFFAABB; lhu at 0x2006 -> 0x00008899.
- Sub-word store RMW with 2 wait cycles per phase: word=0x11223344, sb wdata=0xEE at 0x2001 -> one read then one write with m_wdata=0x1122EE44. done after 1+2+1+2+1 cycles; m_* signals stable while waiting.
- Word store: sw wdata=0xDEADBEEF at 0x27FC -> single write, m_we=1, m_addr=0x27FC, no read issued.
- Errors: lw at 0x2002, lh at 0x2001, sw at 0x2800, lb at 0x1FFF, size=11 -> m_valid never asserts, done=err=1 one cycle after req.
- Reset mid-access: m_ready held 0 in READ, assert rst for 1 cycle -> m_valid=0 and stall follows req after the edge, no done pulse; a following lw completes normally.

Source files
------------

// File: rtl/lsu_initiator.sv
// Load/store initiator: turns CPU byte/half/word accesses into word-aligned
// valid/ready memory transactions, using read-modify-write for sub-word stores.
module lsu_initiator #(
  parameter logic [31:0] BASE  = 32'h0000_2000,
  parameter int          WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        is_store_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_ld_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        m_valid_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_ready_i,
  input  logic [31:0] m_rdata_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(4 * WORDS);

  state_t      state_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        store_q;
  logic        unsigned_q;
  logic [15:0] wdata_q;

  logic badAlign;
  logic outOfRange;
  logic reqError;

  always_comb begin
    badAlign = 1'b0;
    case (size_i)
      2'b01:   badAlign = addr_i[0];
      2'b10:   badAlign = (addr_i[1:0] != 2'b00);
      2'b11:   badAlign = 1'b1;
      default: badAlign = 1'b0;
    endcase
    outOfRange = (addr_i < BASE) || ({1'b0, addr_i} >= LIMIT);
    reqError   = badAlign | outOfRange;
  end

  assign stall_o = (state_q == READ) || (state_q == WRITE) || ((state_q == IDLE) && req_i);

  function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mergeStore(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // done/err default low so every RESP entry yields a single-cycle pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 16'b0;
      m_valid_o  <= 1'b0;
      m_we_o     <= 1'b0;
      m_addr_o   <= 32'b0;
      m_wdata_o  <= 32'b0;
      rdata_o    <= 32'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            lane_q     <= addr_i[1:0];
            size_q     <= size_i;
            store_q    <= is_store_i;
            unsigned_q <= unsigned_ld_i;
            wdata_q    <= wdata_i[15:0];
            if (reqError) begin
              state_q <= RESP;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
              rdata_o <= 32'b0;
            end else begin
              m_valid_o <= 1'b1;
              m_addr_o  <= {addr_i[31:2], 2'b00};
              if (is_store_i && (size_i == 2'b10)) begin
                state_q   <= WRITE;
                m_we_o    <= 1'b1;
                m_wdata_o <= wdata_i;
              end else begin
                state_q <= READ;
                m_we_o  <= 1'b0;
              end
            end
          end
        end
        READ: begin
          if (m_ready_i) begin
            if (store_q) begin
              state_q   <= WRITE;
              m_we_o    <= 1'b1;
              m_wdata_o <= mergeStore(m_rdata_i, lane_q, size_q, wdata_q);
            end else begin
              state_q   <= RESP;
              m_valid_o <= 1'b0;
              done_o    <= 1'b1;
              rdata_o   <= extractLoad(m_rdata_i, lane_q, size_q, unsigned_q);
            end
          end
        end
        WRITE: begin
          if (m_ready_i) begin
            state_q   <= RESP;
            m_valid_o <= 1'b0;
            m_we_o    <= 1'b0;
            done_o    <= 1'b1;
            rdata_o   <= 32'b0;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
